// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: byte width, FSM encoding and the synchronized pin bundle.
package spi_pkg;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = $clog2(BYTE_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   typedef struct packed {
      logic sclk;
      logic ncs;
      logic mosi;
   } spi_pins_t;

   // Bus-idle levels: clock low (mode 0), chip select deasserted.
   localparam spi_pins_t PINS_IDLE = '{sclk: 1'b0, ncs: 1'b1, mosi: 1'b0};

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for the SPI pins; resets to the bus-idle levels.
module spi_sync
   import spi_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  spi_pins_t d,
   output spi_pins_t q
);

   spi_pins_t meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= PINS_IDLE;
         q    <= PINS_IDLE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, with single-byte RX and TX holding registers.
module spi_slave
   import spi_pkg::*;
#(
   parameter logic [BYTE_W-1:0] IDLE_FILL = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              sclk_i,
   input  logic              ncs_i,
   input  logic              mosi_i,
   output logic              miso_o,
   output logic              miso_oe,
   output logic              active,
   input  logic              rx_read,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_full,
   output logic              rx_empty,
   output logic              overrun,
   input  logic              tx_write,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              tx_full,
   output logic              tx_empty,
   output logic              underrun
);

   spi_pins_t         pins_raw, pins_s;
   logic              sclk_d, ncs_d;
   logic              sclk_rise, sclk_fall, ncs_fall;
   state_t            state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic              byte_done;
   logic [BYTE_W-1:0] tx_sr, rx_sr, tx_hold;
   logic              last_rise, tx_accept;

   assign pins_raw.sclk = sclk_i;
   assign pins_raw.ncs  = ncs_i;
   assign pins_raw.mosi = mosi_i;

   spi_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pins_raw),
      .q   (pins_s)
   );

   assign sclk_rise = pins_s.sclk & ~sclk_d;
   assign sclk_fall = ~pins_s.sclk & sclk_d;
   assign ncs_fall  = ~pins_s.ncs & ncs_d;
   assign last_rise = (state == SHIFT) & sclk_rise & (bit_cnt == CNT_W'(BYTE_W - 1));
   // A write landing on the LOAD cycle is accepted even if the holder is full,
   // because LOAD empties it on the same edge.
   assign tx_accept = tx_write & (~tx_full | (state == LOAD));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (enable && ncs_fall) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (byte_done && sclk_fall) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
      if (pins_s.ncs || !enable) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_d    <= 1'b0;
         ncs_d     <= 1'b1;
         bit_cnt   <= '0;
         byte_done <= 1'b0;
         rx_sr     <= '0;
         tx_sr     <= '0;
      end else begin
         sclk_d <= pins_s.sclk;
         ncs_d  <= pins_s.ncs;
         // Leaving the frame drops any partial byte.
         if (state_nxt == IDLE) begin
            bit_cnt   <= '0;
            byte_done <= 1'b0;
         end else if (state == LOAD) begin
            byte_done <= 1'b0;
         end else if (state == SHIFT && sclk_rise) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            rx_sr   <= {rx_sr[BYTE_W-2:0], pins_s.mosi};
            if (last_rise) byte_done <= 1'b1;
         end
         if (state == LOAD)
            tx_sr <= tx_full ? tx_hold : IDLE_FILL;
         else if (state == SHIFT && sclk_fall)
            tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data  <= '0;
         rx_full  <= 1'b0;
         overrun  <= 1'b0;
         tx_hold  <= '0;
         tx_full  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (last_rise) begin
            rx_data <= {rx_sr[BYTE_W-2:0], pins_s.mosi};
            rx_full <= 1'b1;
            if (rx_full && !rx_read) overrun <= 1'b1;
         end else if (rx_read) begin
            rx_full <= 1'b0;
         end
         if (state == LOAD && !tx_full) underrun <= 1'b1;
         if (tx_accept) begin
            tx_hold <= tx_data;
            tx_full <= 1'b1;
         end else if (state == LOAD) begin
            tx_full <= 1'b0;
         end
      end
   end

   assign miso_o   = tx_sr[BYTE_W-1];
   assign miso_oe  = ~pins_s.ncs & enable & (state != IDLE);
   assign active   = (state != IDLE);
   assign rx_empty = ~rx_full;
   assign tx_empty = ~tx_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed + randomized bench for spi_slave against a byte-level transaction model.
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       sclk_i = 1'b0;
   logic       ncs_i = 1'b1;
   logic       mosi_i = 1'b0;
   logic       rx_read = 1'b0;
   logic       tx_write = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       miso_o, miso_oe, active, rx_full, rx_empty, overrun;
   logic       tx_full, tx_empty, underrun;
   logic [7:0] rx_data;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [7:0] FILL = 8'h00;

   // Byte-level model of the holding registers and sticky flags
   logic [7:0] m_rx_data, m_tx_hold, exp_miso;
   bit         m_rx_full, m_overrun, m_tx_full, m_underrun;

   spi_slave #(.IDLE_FILL(FILL)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .sclk_i   (sclk_i),
      .ncs_i    (ncs_i),
      .mosi_i   (mosi_i),
      .miso_o   (miso_o),
      .miso_oe  (miso_oe),
      .active   (active),
      .rx_read  (rx_read),
      .rx_data  (rx_data),
      .rx_full  (rx_full),
      .rx_empty (rx_empty),
      .overrun  (overrun),
      .tx_write (tx_write),
      .tx_data  (tx_data),
      .tx_full  (tx_full),
      .tx_empty (tx_empty),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_rx_data = 8'h00; m_tx_hold = 8'h00; exp_miso = 8'h00;
      m_rx_full = 0; m_overrun = 0; m_tx_full = 0; m_underrun = 0;
   endtask

   // Each byte slot starts by taking the held TX byte, or the fill byte if none.
   task automatic m_load();
      exp_miso = m_tx_full ? m_tx_hold : FILL;
      if (!m_tx_full) m_underrun = 1;
      m_tx_full = 0;
   endtask

   task automatic m_tx_write(input logic [7:0] d);
      if (!m_tx_full) begin
         m_tx_hold = d;
         m_tx_full = 1;
      end
   endtask

   task automatic m_done(input logic [7:0] b, input bit rd);
      if (m_rx_full && !rd) m_overrun = 1;
      m_rx_data = b;
      m_rx_full = 1;
   endtask

   task automatic chk_status(input string tag);
      chk8({tag, "/rx_data"},  rx_data,  m_rx_data);
      chk1({tag, "/rx_full"},  rx_full,  m_rx_full);
      chk1({tag, "/rx_empty"}, rx_empty, !m_rx_full);
      chk1({tag, "/overrun"},  overrun,  m_overrun);
      chk1({tag, "/tx_full"},  tx_full,  m_tx_full);
      chk1({tag, "/tx_empty"}, tx_empty, !m_tx_full);
      chk1({tag, "/underrun"}, underrun, m_underrun);
   endtask

   task automatic do_write(input logic [7:0] d);
      tx_data  = d;
      tx_write = 1'b1;
      @(negedge clk);
      tx_write = 1'b0;
      m_tx_write(d);
   endtask

   task automatic do_read();
      rx_read = 1'b1;
      @(negedge clk);
      rx_read = 1'b0;
      m_rx_full = 0;
   endtask

   // Lower ncs; optionally strobe tx_write on the cycle the slave performs its load.
   task automatic frame_start(input bit wr, input logic [7:0] d, input string tag);
      ncs_i = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (wr && i == 3) begin
            tx_data  = d;
            tx_write = 1'b1;
         end
         if (i == 4) tx_write = 1'b0;
      end
      m_load();
      if (wr) m_tx_write(d);
      chk1({tag, "/active"},  active,  1'b1);
      chk1({tag, "/miso_oe"}, miso_oe, 1'b1);
   endtask

   // Master side: drive nbits MSB-first, sample miso before each rising sclk.
   task automatic xfer(input logic [7:0] b, input int nbits, input bit rd, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         mosi_i = b[i];
         repeat (4) @(negedge clk);
         r[i]   = miso_o;
         sclk_i = 1'b1;
         for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (rd && i == 0 && j == 2) rx_read = 1'b1;
            if (j == 3) rx_read = 1'b0;
         end
         sclk_i = 1'b0;
         repeat (4) @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic byte_io(input logic [7:0] b, input bit rd, input string tag, output logic [7:0] got);
      logic [7:0] e;
      e = exp_miso;
      xfer(b, 8, rd, got);
      chk8({tag, "/miso"}, got, e);
      m_done(b, rd);
      m_load();
      chk8({tag, "/rx_data"}, rx_data, m_rx_data);
   endtask

   task automatic frame_end(input string tag);
      ncs_i  = 1'b1;
      mosi_i = 1'b0;
      repeat (4) @(negedge clk);
      chk1({tag, "/idle_active"},  active,  1'b0);
      chk1({tag, "/idle_miso_oe"}, miso_oe, 1'b0);
      chk_status(tag);
   endtask

   initial begin
      logic [7:0] got, g0, g1, d, t;

      m_reset();
      repeat (3) @(negedge clk);
      chk_status("reset");
      chk1("reset/miso_o", miso_o, 1'b0);
      chk1("reset/miso_oe", miso_oe, 1'b0);
      chk1("reset/active", active, 1'b0);
      rst = 1'b1;
      enable = 1'b1;
      repeat (2) @(negedge clk);

      // Basic byte: A5 out, 3C in
      do_write(8'hA5);
      chk1("a5/tx_full", tx_full, 1'b1);
      frame_start(0, 8'h00, "a5");
      byte_io(8'h3C, 0, "a5", got);
      frame_end("a5");
      chk8("a5/miso_byte", got, 8'hA5);
      chk8("a5/rx_data_exact", rx_data, 8'h3C);
      chk1("a5/rx_full_exact", rx_full, 1'b1);
      chk1("a5/tx_empty_exact", tx_empty, 1'b1);

      // rx_read coincident with completion: no overrun, byte kept
      d = 8'($urandom);
      frame_start(0, 8'h00, "rdco");
      byte_io(d, 1, "rdco", got);
      frame_end("rdco");
      chk1("rdco/rx_full_exact", rx_full, 1'b1);
      chk1("rdco/overrun_exact", overrun, 1'b0);
      chk8("rdco/fill", got, FILL);

      // rx_read while empty is harmless
      do_read();
      do_read();
      chk_status("rd_empty");

      // ncs raised after 4 bits, then a clean byte
      frame_start(0, 8'h00, "part");
      xfer(8'($urandom), 4, 0, got);
      frame_end("part");
      t = 8'($urandom);
      do_write(t);
      d = 8'($urandom);
      frame_start(0, 8'h00, "after_part");
      byte_io(d, 0, "after_part", got);
      frame_end("after_part");
      chk8("after_part/rx_exact", rx_data, d);
      chk8("after_part/miso_exact", got, t);

      // Two-byte frame with only one queued TX byte
      do_read();
      t = 8'($urandom);
      do_write(t);
      frame_start(0, 8'h00, "two");
      byte_io(8'($urandom), 0, "two0", g0);
      byte_io(8'($urandom), 1, "two1", g1);
      frame_end("two");
      chk8("two/miso0", g0, t);
      chk8("two/miso1", g1, 8'h00);
      chk1("two/underrun", underrun, 1'b1);

      // Two bytes without reading
      frame_start(0, 8'h00, "ovr");
      byte_io(8'h11, 0, "ovr0", got);
      byte_io(8'h22, 0, "ovr1", got);
      frame_end("ovr");
      chk8("ovr/rx_data", rx_data, 8'h22);
      chk1("ovr/overrun", overrun, 1'b1);

      // tx_write on the load cycle is not bypassed
      t = 8'($urandom);
      frame_start(1, t, "ldwr");
      byte_io(8'($urandom), 0, "ldwr0", g0);
      byte_io(8'($urandom), 0, "ldwr1", g1);
      frame_end("ldwr");
      chk8("ldwr/miso0", g0, FILL);
      chk8("ldwr/miso1", g1, t);

      // Disabled: frame ignored entirely
      do_read();
      enable = 1'b0;
      ncs_i = 1'b0;
      repeat (8) @(negedge clk);
      chk1("dis/active", active, 1'b0);
      chk1("dis/miso_oe", miso_oe, 1'b0);
      xfer(8'($urandom), 8, 0, got);
      ncs_i = 1'b1;
      repeat (4) @(negedge clk);
      enable = 1'b1;
      repeat (2) @(negedge clk);
      chk_status("dis");

      // Randomized frames
      for (int f = 0; f < 5; f++) begin
         int nb;
         if ($urandom_range(1) == 1) do_write(8'($urandom));
         if ($urandom_range(1) == 1) do_read();
         frame_start(1'($urandom_range(1)), 8'($urandom), "rnd");
         nb = int'($urandom_range(3, 1));
         for (int k = 0; k < nb; k++) byte_io(8'($urandom), 1'($urandom_range(1)), "rnd", got);
         frame_end("rnd");
      end

      // Asynchronous reset mid-byte
      frame_start(0, 8'h00, "rstmid");
      xfer(8'($urandom), 4, 0, got);
      do_write(8'h5A);
      chk1("rstmid/tx_full_pre", tx_full, 1'b1);
      sclk_i = 1'b1;
      @(negedge clk);
      #3 rst = 1'b0;
      #1;
      m_reset();
      chk_status("rstmid");
      chk1("rstmid/miso_o", miso_o, 1'b0);
      chk1("rstmid/miso_oe", miso_oe, 1'b0);
      chk1("rstmid/active", active, 1'b0);
      sclk_i = 1'b0;
      ncs_i  = 1'b1;
      mosi_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk1("post_rst/active", active, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter IDLE_FILL, default 8'h00: byte shifted out on miso_o when no TX byte is available at a byte load.
REQ-002 clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 enable  input  1  block enable; when low, frames are ignored.
REQ-005 sclk_i  input  1  SPI serial clock from the external master, asynchronous to clk.
REQ-006 ncs_i  input  1  SPI chip select from the master, active-low, asynchronous.
REQ-007 mosi_i  input  1  serial data from the master.
REQ-008 miso_o  output  1  serial data to the master.
REQ-009 miso_oe  output  1  miso output enable, high while selected and enabled.
REQ-010 active  output  1  high whenever the FSM is not IDLE.
REQ-011 rx_read  input  1  pop strobe for the received byte.
REQ-012 rx_data  output  8  last received byte.
REQ-013 rx_full  output  1  received byte held and not yet read.
REQ-014 rx_empty  output  1  inverse of rx_full.
REQ-015 overrun  output  1  sticky: a byte completed while rx_full was high.
REQ-016 tx_write  input  1  push strobe for tx_data.
REQ-017 tx_data  input  8  byte to return to the master.
REQ-018 tx_full  output  1  TX holding register occupied.
REQ-019 tx_empty  output  1  inverse of tx_full.
REQ-020 underrun  output  1  sticky: a byte load found tx_empty high, so IDLE_FILL was sent.

Function
REQ-021 sclk_i, ncs_i and mosi_i are each synchronized through two flops; edge detection uses the synchronized sclk and its one-cycle-delayed copy; the supported sclk frequency is at most clk/8.
REQ-022 Protocol is SPI mode 0, MSB first, 8-bit bytes: mosi is sampled on the rising edge of sclk; miso changes on the falling edge of sclk.
REQ-023 FSM states: IDLE, LOAD, SHIFT. IDLE->LOAD on synchronized ncs falling while enable=1. LOAD->SHIFT after one cycle. SHIFT->LOAD on the falling sclk edge that follows the 8th rising edge. Any state->IDLE on synchronized ncs high or enable=0.
REQ-024 LOAD copies the TX holding register into the TX shift register and clears tx_full; if tx_empty=1, LOAD copies IDLE_FILL instead and sets underrun; miso_o equals bit 7 of the TX shift register.
REQ-025 A 3-bit counter increments on each synchronized sclk rising edge in SHIFT and wraps 7->0; the RX shift register takes mosi on the same edge.
REQ-026 On the 8th rising edge (detected in cycle N), rx_data is updated and rx_full=1 in cycle N+1.
REQ-027 If rx_full=1 when a byte completes, rx_data is overwritten and overrun is set.
REQ-028 rx_read and a byte completion in the same cycle: the new byte is stored, rx_full stays 1, and overrun is not set.
REQ-029 rx_read while rx_empty=1 has no effect.
REQ-030 tx_write while tx_full=0 stores tx_data and sets tx_full the next cycle; tx_write while tx_full=1 is ignored.
REQ-031 tx_write in the same cycle as LOAD is not bypassed: LOAD uses the prior register contents, and the write is stored for the next byte.
REQ-032 ncs deasserting mid-byte discards the partial byte: the bit counter is cleared, and rx_data and rx_full are unchanged.
REQ-033 Multi-byte frames: consecutive bytes within one ncs-low period each pass through LOAD.
REQ-034 miso_oe = synchronized ncs low AND enable AND state != IDLE.
REQ-035 overrun and underrun clear only on reset.

Reset
REQ-036 While rst=0: state=IDLE, counter=0, shift registers=0, rx_data=8'h00, rx_full=0, rx_empty=1, tx_full=0, tx_empty=1, overrun=0, underrun=0, miso_o=0, miso_oe=0, active=0, and synchronizer flops hold the idle values (sclk=0, ncs=1).

Structure
REQ-037 FSM state encodings and the byte-width constant (8) reside in a shared package, spi_pkg.
REQ-038 The three-input 2-flop synchronizer is a sub-module, spi_sync.

Verification
REQ-039 tx_write 8'hA5, then ncs low and 8 sclk with mosi=8'h3C -> miso yields 8'hA5; rx_data=8'h3C; rx_full=1; tx_empty=1.
REQ-040 Two-byte frame with no second tx_write -> second miso byte=8'h00; underrun=1.
REQ-041 Two bytes 8'h11 then 8'h22 received without rx_read -> rx_data=8'h22; overrun=1.
REQ-042 ncs raised after 4 bits -> rx_full unchanged; the next full frame receives correctly.
REQ-043 rst asserted mid-byte -> all outputs take their reset values immediately, with no clk edge required.
REQ-044 rx_read coincident with byte completion -> rx_full=1; overrun=0.
